// File: rtl/mult_operand_seq.sv
// rtl/mult_operand_seq.sv - operand loader and result capture for the 4-bit multiplier
module mult_operand_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in,
    input  logic       load,
    input  logic       clear,
    input  logic [3:0] Result,
    input  logic       Overflow,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] res_q,
    output logic       ov_q,
    output logic       ov_sticky,
    output logic       valid,
    output logic [3:0] op_count,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        CALC   = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t     cur_state, nxt_state;
    logic       load_prev, load_edge;
    logic [3:0] a_nxt, b_nxt, res_nxt, cnt_nxt;
    logic       ov_nxt, sticky_nxt, valid_nxt;

    // Resets high so a load held through reset release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) load_prev <= 1'b1;
        else     load_prev <= load;
    end

    assign load_edge = load & ~load_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= LOAD_A;
            A         <= 4'd0;
            B         <= 4'd0;
            res_q     <= 4'd0;
            ov_q      <= 1'b0;
            ov_sticky <= 1'b0;
            valid     <= 1'b0;
            op_count  <= 4'd0;
        end else begin
            cur_state <= nxt_state;
            A         <= a_nxt;
            B         <= b_nxt;
            res_q     <= res_nxt;
            ov_q      <= ov_nxt;
            ov_sticky <= sticky_nxt;
            valid     <= valid_nxt;
            op_count  <= cnt_nxt;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        a_nxt      = A;
        b_nxt      = B;
        res_nxt    = res_q;
        ov_nxt     = ov_q;
        sticky_nxt = ov_sticky;
        valid_nxt  = valid;
        cnt_nxt    = op_count;
        if (clear) begin
            nxt_state  = LOAD_A;
            a_nxt      = 4'd0;
            b_nxt      = 4'd0;
            res_nxt    = 4'd0;
            ov_nxt     = 1'b0;
            sticky_nxt = 1'b0;
            valid_nxt  = 1'b0;
            cnt_nxt    = 4'd0;
        end else begin
            case (cur_state)
                LOAD_A: if (load_edge) begin
                    a_nxt     = data_in;
                    nxt_state = LOAD_B;
                end
                LOAD_B: if (load_edge) begin
                    b_nxt     = data_in;
                    nxt_state = CALC;
                end
                // Operands have been stable for a full cycle; capture the product.
                CALC: begin
                    res_nxt    = Result;
                    ov_nxt     = Overflow;
                    valid_nxt  = 1'b1;
                    sticky_nxt = ov_sticky | Overflow;
                    cnt_nxt    = (op_count == 4'd15) ? op_count : op_count + 4'd1;
                    nxt_state  = DONE;
                end
                DONE: if (load_edge) begin
                    a_nxt     = data_in;
                    valid_nxt = 1'b0;
                    nxt_state = LOAD_B;
                end
                default: nxt_state = LOAD_A;
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_mult_operand_seq.sv
// tb/tb_mult_operand_seq.sv - self-checking bench for mult_operand_seq
module tb_mult_operand_seq;

    logic       clk = 1'b0;
    logic       rst, load, clear;
    logic [3:0] data_in;
    logic [3:0] Result;
    logic       Overflow;
    logic [3:0] A, B, res_q, op_count;
    logic       ov_q, ov_sticky, valid;
    logic [1:0] state;
    logic [7:0] prod;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected architectural state
    int m_a, m_b, m_res, m_ov, m_sticky, m_cnt, m_valid, m_state;

    mult_operand_seq dut (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load), .clear(clear),
        .Result(Result), .Overflow(Overflow),
        .A(A), .B(B), .res_q(res_q), .ov_q(ov_q), .ov_sticky(ov_sticky),
        .valid(valid), .op_count(op_count), .state(state)
    );

    // Combinational multiplier the block drives
    assign prod     = {4'd0, A} * {4'd0, B};
    assign Result   = prod[3:0];
    assign Overflow = (prod > 8'd15);

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},     int'(state),     m_state);
        chk({tag, ".A"},         int'(A),         m_a);
        chk({tag, ".B"},         int'(B),         m_b);
        chk({tag, ".res_q"},     int'(res_q),     m_res);
        chk({tag, ".ov_q"},      int'(ov_q),      m_ov);
        chk({tag, ".ov_sticky"}, int'(ov_sticky), m_sticky);
        chk({tag, ".valid"},     int'(valid),     m_valid);
        chk({tag, ".op_count"},  int'(op_count),  m_cnt);
    endtask

    task automatic model_zero();
        m_a = 0; m_b = 0; m_res = 0; m_ov = 0; m_sticky = 0;
        m_cnt = 0; m_valid = 0; m_state = 0;
    endtask

    // Operand A edge; optionally keep load high for extra cycles
    task automatic load_a(input int v, input int hold);
        data_in = 4'(v);
        load    = 1'b1;
        step();
        m_a = v; m_valid = 0; m_state = 1;
        check_all("load_a");
        for (int i = 0; i < hold; i++) begin
            data_in = 4'($urandom);
            step();
        end
        if (hold > 0) check_all("hold_a");
        load = 1'b0;
        step();
    endtask

    // Operand B edge, then the CALC cycle
    task automatic load_b(input int v);
        data_in = 4'(v);
        load    = 1'b1;
        step();
        m_b = v; m_state = 2;
        check_all("calc");
        load = 1'b0;
        step();
        m_res    = (m_a * m_b) % 16;
        m_ov     = (m_a * m_b > 15) ? 1 : 0;
        m_sticky = m_sticky | m_ov;
        m_cnt    = (m_cnt < 15) ? m_cnt + 1 : 15;
        m_valid  = 1;
        m_state  = 3;
        check_all("done");
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; clear = 1'b0; data_in = 4'd7;
        model_zero();
        step();
        step();
        check_all("reset");

        // Release reset with load already high: no edge must fire
        rst = 1'b0;
        step(); step(); step();
        check_all("no_edge_after_reset");
        load = 1'b0;
        step();

        load_a(3, 0);
        load_b(5);
        load_a(4, 0);
        load_b(4);
        load_a(2, 0);
        load_b(3);
        chk("sticky_kept", int'(ov_sticky), 1);
        load_a(15, 0);
        load_b(15);
        load_a(7, 10);
        load_b(2);

        // Clear beats a load edge in LOAD_B
        load_a(5, 0);
        data_in = 4'd6; load = 1'b1; clear = 1'b1;
        step();
        model_zero();
        check_all("clear_vs_edge");
        clear = 1'b0; load = 1'b0;
        step();
        check_all("after_clear");

        for (int i = 0; i < 17; i++) begin
            load_a(int'($urandom_range(0, 15)), 0);
            load_b(int'($urandom_range(0, 15)));
        end
        chk("cnt_saturated", int'(op_count), 15);

        // Asynchronous reset while in CALC
        load_a(int'($urandom_range(0, 15)), 0);
        data_in = 4'd9; load = 1'b1;
        step();
        chk("in_calc", int'(state), 2);
        #2 rst = 1'b1;
        #1;
        model_zero();
        check_all("async_reset");
        load = 1'b0;
        step();
        check_all("reset_held");
        rst = 1'b0;
        step(); step();
        check_all("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_operand_seq.md
# mult_operand_seq

Sequential front end for the combinational 4-bit multiplier. It loads operands A and B one after the other from a single 4-bit data bus, each load triggered by a rising edge on a load pulse. It then drives the operands into the multiplier, registers the multiplier's Result and Overflow one cycle later, and flags them valid. It also keeps a sticky overflow flag and a saturating count of completed operations for the board display logic.

## Interface

Parameters:
- none; all widths are fixed at 4 bits to match the multiplier.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- data_in  in  4  operand value, sampled on a load edge
- load  in  1  load request; synchronous and debounced upstream; only its rising edge acts
- clear  in  1  synchronous clear of all state, excluding the reset-only behaviour of load_prev
- Result  in  4  multiplier low product bits (A×B mod 16)
- Overflow  in  1  multiplier overflow (A×B > 15)
- A  out  4  registered operand A to the multiplier
- B  out  4  registered operand B to the multiplier
- res_q  out  4  captured product
- ov_q  out  1  captured overflow of the last operation
- ov_sticky  out  1  OR of ov_q over all operations since the last reset or clear
- valid  out  1  res_q and ov_q hold a completed operation
- op_count  out  4  completed operations, saturating at 15
- state  out  2  FSM state encoding, for debug LEDs

## Operation

- Edge detect: load_edge = load & ~load_prev. load_prev is a register updated every cycle.
  - load_prev resets to 1, so a load held high through reset release does not fire.
  - Holding load high produces exactly one edge.
- FSM states:
  - LOAD_A = 00
  - LOAD_B = 01
  - CALC = 10
  - DONE = 11
- LOAD_A: on load_edge, A <= data_in and go to LOAD_B.
- LOAD_B: on load_edge, B <= data_in and go to CALC.
- CALC (lasts one cycle, gives the combinational path time to settle), unconditionally:
  - res_q <= Result, ov_q <= Overflow, valid <= 1
  - ov_sticky <= ov_sticky | Overflow
  - op_count <= op_count + 1, holding at 15
  - go to DONE
  - load_edge is ignored in this state.
- DONE: outputs hold.
  - On load_edge: A <= data_in, valid <= 0, go to LOAD_B.
  - res_q and ov_q keep the old values until the next CALC.
- B keeps its value until it is overwritten in LOAD_B.
- clear (any state) goes to LOAD_A and zeroes A, B, res_q, ov_q, ov_sticky, valid and op_count.
  - clear has priority over load_edge in the same cycle.
  - load_prev still updates on a clear cycle.
- Arithmetic: this block does no arithmetic except the op_count increment. Product width and overflow are defined by the multiplier.

## Timing

- Reset values:
  - state = LOAD_A
  - A, B, res_q = 0000
  - ov_q, ov_sticky, valid = 0
  - op_count = 0000
  - load_prev = 1
- Reset is asynchronous. Asserting it mid-operation, including during CALC, aborts immediately with no capture.
- Latency from the B load edge (cycle n, load high and load_prev low):
  - B updates at the end of cycle n; the FSM is in CALC during cycle n+1.
  - res_q and valid update at the end of cycle n+1 and are visible in cycle n+2.
- valid deasserts one cycle after the A load edge seen in DONE.
- A and B change only on their load edge or on clear, so the multiplier inputs are stable throughout CALC.
- Back-to-back edges need load low for at least one cycle between them.

## Test plan

- Reset, then load 3 and then 5 → res_q = 1111, ov_q = 0, valid = 1 exactly 2 cycles after the B edge, op_count = 1, state = DONE.
- Load 4 and 4 → res_q = 0000, ov_q = 1, ov_sticky = 1. Then load 2 and 3 → res_q = 0110, ov_q = 0, ov_sticky stays 1.
- Load 15 and 15 → res_q = 0001, ov_q = 1. Hold load high for 10 cycles after the A edge → state stays LOAD_B, B is unchanged.
- Load high while rst is deasserted → no edge, state stays LOAD_A. Assert clear and load_edge in the same cycle while in LOAD_B → state = LOAD_A and all outputs zero.
- Run 17 operations → op_count saturates at 15. Then assert rst asynchronously while in CALC → all outputs return to their reset values with no clock edge, and valid stays 0.
